// File: rtl/ap_seq_pkg.sv
// Shared types and default constants for the audio-processing run-control sequencer.
package ap_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_CAPTURE    = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_WAIT_STATS = 3'd4,
        ST_PRESENT    = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;

    localparam int CLK_DIV_DEF    = 6250;
    localparam int FFT_BINS_DEF   = 64;
    localparam int NUM_FRAMES_DEF = 49;
    localparam int TIMEOUT_DEF    = 4096;
    localparam int CLEAR_CYCLES   = 2;

    // Counter width for a modulo-n count, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == ST_CLEAR) || (s == ST_CAPTURE) || (s == ST_DRAIN) ||
               (s == ST_WAIT_STATS) || (s == ST_PRESENT);
    endfunction

    // States in which a stalled pipeline is detected.
    function automatic logic is_watched(input state_t s);
        return (s == ST_CAPTURE) || (s == ST_DRAIN) || (s == ST_WAIT_STATS);
    endfunction

endpackage

// File: rtl/ap_sample_div.sv
// Audio sample-rate divider: registered one-cycle strobe every CLK_DIV enabled cycles.
module ap_sample_div
    import ap_seq_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV_W = cnt_w(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            // Strobe lands the cycle after the count sits at its last value.
            tick_d = (cnt_q == DIV_LAST);
            cnt_d  = (cnt_q == DIV_LAST) ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ap_sequencer.sv
// Run-control FSM for the audio chain: clear, capture, drain, wait for stats,
// present the feature vector, with a stall watchdog and abort.
module ap_sequencer
    import ap_seq_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int FFT_BINS   = FFT_BINS_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            frame_ready,
    input  logic                            fft_en,
    input  logic                            stats_valid,
    input  logic                            vector_ready,
    output logic                            sample_en,
    output logic                            pipe_rst,
    output logic                            vector_valid,
    output logic                            busy,
    output logic                            error,
    output logic [$clog2(NUM_FRAMES+1)-1:0] frame_cnt,
    output logic [2:0]                      state_o
);

    localparam int FC_W  = $clog2(NUM_FRAMES + 1);
    localparam int BIN_W = cnt_w(FFT_BINS);
    localparam int WD_W  = cnt_w(TIMEOUT);
    localparam int CC_W  = cnt_w(CLEAR_CYCLES);

    localparam logic [FC_W-1:0]  FRAMES_MAX = FC_W'(NUM_FRAMES);
    localparam logic [BIN_W-1:0] BIN_LAST   = BIN_W'(FFT_BINS - 1);
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [CC_W-1:0]  CC_LAST    = CC_W'(CLEAR_CYCLES - 1);

    state_t           state_q, state_d;
    logic             clr_to_cap_q, clr_to_cap_d;
    logic [CC_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d, frame_cnt_nxt;
    logic [FC_W-1:0]  fft_frames_q, fft_frames_d, fft_frames_nxt;
    logic [BIN_W-1:0] bin_cnt_q, bin_cnt_d, bin_cnt_nxt;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             stats_pend_q, stats_pend_d;
    logic             error_q, error_d;
    logic             pipe_rst_q, pipe_rst_d;
    logic             vector_valid_q, vector_valid_d;
    logic             busy_q, busy_d;

    logic progress, wd_fire, clear_ctrs, div_en, div_clr;

    assign progress = frame_ready | fft_en | stats_valid;
    assign wd_fire  = (wd_q == WD_LAST) && !progress;

    // Counter look-ahead without the CLEAR override, so next-state logic
    // can see the post-event value without a loop through state_d.
    always_comb begin
        frame_cnt_nxt  = frame_cnt_q;
        bin_cnt_nxt    = bin_cnt_q;
        fft_frames_nxt = fft_frames_q;
        if (state_q == ST_CAPTURE && frame_ready)
            frame_cnt_nxt = frame_cnt_q + FC_W'(1);
        if (state_q != ST_IDLE && fft_en) begin
            if (bin_cnt_q == BIN_LAST) begin
                bin_cnt_nxt = '0;
                if (fft_frames_q != FRAMES_MAX)
                    fft_frames_nxt = fft_frames_q + FC_W'(1);
            end else begin
                bin_cnt_nxt = bin_cnt_q + BIN_W'(1);
            end
        end
    end

    // Next-state logic; abort outranks every other request.
    always_comb begin
        state_d      = state_q;
        clr_to_cap_d = clr_to_cap_q;
        if (abort && state_q != ST_IDLE) begin
            state_d      = ST_CLEAR;
            clr_to_cap_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (start) begin
                        state_d      = ST_CLEAR;
                        clr_to_cap_d = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == CC_LAST)
                        state_d = clr_to_cap_q ? ST_CAPTURE : ST_IDLE;
                end
                ST_CAPTURE: begin
                    if (frame_cnt_nxt == FRAMES_MAX) state_d = ST_DRAIN;
                    else if (wd_fire)                state_d = ST_ERROR;
                end
                ST_DRAIN: begin
                    if (fft_frames_nxt == FRAMES_MAX) state_d = ST_DRAIN == ST_DRAIN ? ST_WAIT_STATS : ST_DRAIN;
                    else if (wd_fire)                 state_d = ST_ERROR;
                end
                ST_WAIT_STATS: begin
                    if (stats_valid || stats_pend_q) state_d = ST_PRESENT;
                    else if (wd_fire)                state_d = ST_ERROR;
                end
                ST_PRESENT: begin
                    if (vector_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign clear_ctrs = (state_d == ST_CLEAR) || (state_q == ST_CLEAR);

    always_comb begin
        clr_cnt_d    = (state_q == ST_CLEAR && !abort) ? clr_cnt_q + CC_W'(1) : '0;
        frame_cnt_d  = clear_ctrs ? '0 : frame_cnt_nxt;
        bin_cnt_d    = clear_ctrs ? '0 : bin_cnt_nxt;
        fft_frames_d = clear_ctrs ? '0 : fft_frames_nxt;
        // Watchdog restarts on any progress event and on every state change.
        wd_d = (is_watched(state_q) && state_d == state_q && !progress) ? wd_q + WD_W'(1) : '0;
        stats_pend_d = stats_pend_q;
        if (clear_ctrs || state_q == ST_WAIT_STATS)
            stats_pend_d = 1'b0;
        else if (stats_valid && (state_q == ST_CAPTURE || state_q == ST_DRAIN))
            stats_pend_d = 1'b1;
    end

    // Registered outputs decode the state being entered.
    always_comb begin
        pipe_rst_d     = (state_d == ST_CLEAR);
        vector_valid_d = (state_d == ST_PRESENT);
        busy_d         = is_busy(state_d);
        error_d        = (state_d == ST_ERROR) || (error_q && state_d != ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            clr_to_cap_q   <= 1'b0;
            clr_cnt_q      <= '0;
            frame_cnt_q    <= '0;
            bin_cnt_q      <= '0;
            fft_frames_q   <= '0;
            wd_q           <= '0;
            stats_pend_q   <= 1'b0;
            error_q        <= 1'b0;
            pipe_rst_q     <= 1'b1;
            vector_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_to_cap_q   <= clr_to_cap_d;
            clr_cnt_q      <= clr_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            bin_cnt_q      <= bin_cnt_d;
            fft_frames_q   <= fft_frames_d;
            wd_q           <= wd_d;
            stats_pend_q   <= stats_pend_d;
            error_q        <= error_d;
            pipe_rst_q     <= pipe_rst_d;
            vector_valid_q <= vector_valid_d;
            busy_q         <= busy_d;
        end
    end

    // Divider only runs while staying in CAPTURE, so no strobe escapes on exit.
    assign div_en  = (state_q == ST_CAPTURE) && (state_d == ST_CAPTURE);
    assign div_clr = (state_q != ST_CAPTURE);

    ap_sample_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (div_clr),
        .tick (sample_en)
    );

    assign pipe_rst     = pipe_rst_q;
    assign vector_valid = vector_valid_q;
    assign busy         = busy_q;
    assign error        = error_q;
    assign frame_cnt    = frame_cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_ap_sequencer.sv
// Directed-random bench for ap_sequencer with a small spec-level expectation model.
module tb_ap_sequencer;
    import ap_seq_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int FFT_BINS   = 4;
    localparam int NUM_FRAMES = 3;
    localparam int TIMEOUT    = 16;
    localparam int FC_W       = $clog2(NUM_FRAMES + 1);

    logic            clk, rst, start, abort, frame_ready, fft_en, stats_valid, vector_ready;
    logic            sample_en, pipe_rst, vector_valid, busy, error;
    logic [FC_W-1:0] frame_cnt;
    logic [2:0]      state_o;

    int vectors     = 0;
    int miscompares = 0;

    ap_sequencer #(
        .CLK_DIV(CLK_DIV), .FFT_BINS(FFT_BINS), .NUM_FRAMES(NUM_FRAMES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_ready(frame_ready),
        .fft_en(fft_en), .stats_valid(stats_valid), .vector_ready(vector_ready),
        .sample_en(sample_en), .pipe_rst(pipe_rst), .vector_valid(vector_valid),
        .busy(busy), .error(error), .frame_cnt(frame_cnt), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs held; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic fr, input logic fe, input logic sv,
                       input logic vr, input logic st, input logic ab);
        frame_ready = fr; fft_en = fe; stats_valid = sv;
        vector_ready = vr; start = st; abort = ab;
        @(posedge clk); #1;
        frame_ready = 0; fft_en = 0; stats_valid = 0;
        vector_ready = 0; start = 0; abort = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    function automatic int fft_frames_model(input int n_en);
        return (n_en / FFT_BINS > NUM_FRAMES) ? NUM_FRAMES : n_en / FFT_BINS;
    endfunction

    // Start pulse, two pipe_rst cycles, arrive in CAPTURE.
    task automatic enter_capture(input string tag);
        cyc(0, 0, 0, 0, 1, 0);
        chk({tag, ".clr0_prst"}, pipe_rst, 1);
        chk({tag, ".clr0_st"}, state_o, ST_CLEAR);
        chk({tag, ".clr0_busy"}, busy, 1);
        chk({tag, ".clr0_err"}, error, 0);
        idle();
        chk({tag, ".clr1_prst"}, pipe_rst, 1);
        idle();
        chk({tag, ".cap_prst"}, pipe_rst, 0);
        chk({tag, ".cap_st"}, state_o, ST_CAPTURE);
        chk({tag, ".cap_fc"}, frame_cnt, 0);
    endtask

    // NUM_FRAMES frame_ready pulses at random spacing; sample_en expected every CLK_DIV cycles.
    task automatic capture_frames(input int gmax);
        int k;
        int g;
        k = 0;
        for (int f = 0; f < NUM_FRAMES; f++) begin
            g = $urandom_range(gmax, 1);
            for (int j = 1; j <= g; j++) begin
                cyc(j == g, 0, 0, 0, 0, 0);
                k++;
                if (j == g && f == NUM_FRAMES - 1) begin
                    chk("cap.last_se", sample_en, 0);
                    chk("cap.drain_st", state_o, ST_DRAIN);
                end else begin
                    chk("cap.se", sample_en, (k % CLK_DIV) == 0);
                end
                if (j == g) chk("cap.fc", frame_cnt, f + 1);
            end
        end
    endtask

    // FFT_BINS*NUM_FRAMES fft_en pulses; optional stats_valid after sv_at of them.
    task automatic drain_fft(input int gmax, input int sv_at);
        int n;
        int g;
        n = 0;
        while (n < FFT_BINS * NUM_FRAMES) begin
            if (n == sv_at) begin
                cyc(0, 0, 1, 0, 0, 0);
                chk("drn.sv_st", state_o, ST_DRAIN);
            end
            g = $urandom_range(gmax, 0);
            for (int j = 0; j < g; j++) begin
                idle();
                chk("drn.gap_st", state_o, ST_DRAIN);
                chk("drn.gap_se", sample_en, 0);
            end
            cyc(0, 1, 0, 0, 0, 0);
            n++;
            chk("drn.st", state_o,
                (fft_frames_model(n) == NUM_FRAMES) ? ST_WAIT_STATS : ST_DRAIN);
        end
    endtask

    initial begin
        int w;
        rst = 1; start = 0; abort = 0; frame_ready = 0;
        fft_en = 0; stats_valid = 0; vector_ready = 0;

        // Reset and idle
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst.prst", pipe_rst, 1);
            chk("rst.se", sample_en, 0);
            chk("rst.vv", vector_valid, 0);
            chk("rst.busy", busy, 0);
            chk("rst.err", error, 0);
            chk("rst.fc", frame_cnt, 0);
            chk("rst.st", state_o, ST_IDLE);
        end
        rst = 0;
        idle();
        chk("idle.prst", pipe_rst, 0);
        for (int i = 0; i < 50; i++) begin
            idle();
            chk("idle.se", sample_en, 0);
        end
        chk("idle.st", state_o, ST_IDLE);

        // Nominal run
        enter_capture("nom");
        capture_frames(6);
        drain_fft(2, -1);
        w = $urandom_range(5, 1);
        for (int i = 0; i < w; i++) begin
            cyc(0, 0, 0, i == 0, 0, 0);
            chk("nom.wait_st", state_o, ST_WAIT_STATS);
            chk("nom.wait_vv", vector_valid, 0);
        end
        cyc(0, 0, 1, 0, 0, 0);
        chk("nom.pres_vv", vector_valid, 1);
        chk("nom.pres_st", state_o, ST_PRESENT);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, i == 2, 0);
            chk("nom.hold_vv", vector_valid, 1);
            chk("nom.hold_st", state_o, ST_PRESENT);
        end
        cyc(0, 0, 0, 1, 0, 0);
        chk("nom.acc_vv", vector_valid, 0);
        chk("nom.acc_st", state_o, ST_IDLE);
        chk("nom.acc_busy", busy, 0);

        // Early stats, then abort while presenting
        enter_capture("early");
        capture_frames(1);
        drain_fft(0, 6);
        chk("early.wait_vv", vector_valid, 0);
        idle();
        chk("early.vv", vector_valid, 1);
        chk("early.st", state_o, ST_PRESENT);
        cyc(0, 0, 0, 0, 0, 1);
        chk("early.ab_vv", vector_valid, 0);
        chk("early.ab_st", state_o, ST_CLEAR);
        chk("early.ab_prst", pipe_rst, 1);
        idle();
        idle();
        chk("early.idle_st", state_o, ST_IDLE);
        chk("early.idle_fc", frame_cnt, 0);

        // Abort in IDLE does nothing
        cyc(0, 0, 0, 0, 0, 1);
        chk("abidle.st", state_o, ST_IDLE);
        chk("abidle.prst", pipe_rst, 0);

        // Watchdog
        enter_capture("wd");
        idle();
        cyc(1, 0, 0, 0, 0, 0);
        chk("wd.fc", frame_cnt, 1);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            idle();
            chk("wd.pre_st", state_o, ST_CAPTURE);
            chk("wd.pre_err", error, 0);
        end
        idle();
        chk("wd.err", error, 1);
        chk("wd.st", state_o, ST_ERROR);
        chk("wd.se", sample_en, 0);
        chk("wd.busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("wd.hold_err", error, 1);
            chk("wd.hold_se", sample_en, 0);
        end
        enter_capture("wd2");
        chk("wd2.err", error, 0);

        // Abort beats start in CAPTURE
        cyc(1, 0, 0, 0, 0, 0);
        chk("ab.fc", frame_cnt, 1);
        w = $urandom_range(5, 1);
        for (int i = 0; i < w; i++) idle();
        cyc(0, 0, 0, 0, 1, 1);
        chk("ab.st", state_o, ST_CLEAR);
        chk("ab.prst0", pipe_rst, 1);
        idle();
        chk("ab.prst1", pipe_rst, 1);
        idle();
        chk("ab.idle_st", state_o, ST_IDLE);
        chk("ab.idle_busy", busy, 0);
        chk("ab.idle_fc", frame_cnt, 0);
        chk("ab.idle_prst", pipe_rst, 0);
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("ab.vv", vector_valid, 0);
            chk("ab.se", sample_en, 0);
        end

        // Saturation: extra frame and extra fft_en
        enter_capture("sat");
        capture_frames(1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("sat.fc", frame_cnt, NUM_FRAMES);
        chk("sat.drain_st", state_o, ST_DRAIN);
        drain_fft(0, -1);
        cyc(0, 1, 1, 0, 0, 0);
        chk("sat.vv", vector_valid, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            chk("sat.hold_vv", vector_valid, 1);
        end
        cyc(0, 0, 0, 1, 0, 0);
        chk("sat.acc_vv", vector_valid, 0);
        chk("sat.acc_st", state_o, ST_IDLE);
        for (int i = 0; i < 8; i++) begin
            idle();
            chk("sat.single_vv", vector_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
